// File: rtl/dma_pkg.sv
// Shared types and register offsets for the DMA transfer sequencer.
// The optional abort input is enabled by defining DMA_ABORT_EN.
package dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        DONE
    } dma_xfer_state_t;

    localparam logic [31:0] DMA_INTR_OFS     = 32'h400;
    localparam logic [31:0] DMA_CTRL_OFS     = 32'h404;
    localparam logic [31:0] DMA_IO_ADDR_OFS  = 32'h408;
    localparam logic [31:0] DMA_MEM_ADDR_OFS = 32'h40C;

endpackage

// File: rtl/dma_addr_gen.sv
// Loadable address register that advances by one bus word per increment.
// Used for both the source and destination pointers of dma_xfer_ctrl.
module dma_addr_gen #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic [ADDR_WIDTH-1:0] i_load_addr,
    input  logic                  i_inc,
    output logic [ADDR_WIDTH-1:0] o_addr
);

    localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(DATA_WIDTH / 8);

    logic [ADDR_WIDTH-1:0] r_addr;

    // Address overflow wraps silently modulo 2^ADDR_WIDTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr <= '0;
        end else if (i_load) begin
            r_addr <= i_load_addr;
        end else if (i_inc) begin
            r_addr <= r_addr + STRIDE;
        end
    end

    assign o_addr = r_addr;

endmodule

// File: rtl/dma_xfer_ctrl.sv
// DMA transfer sequencer: one read then one write per word, sticky interrupt at end.
// Define DMA_ABORT_EN to add the abort input that cuts a transfer short.
module dma_xfer_ctrl
    import dma_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_start,
    input  logic [ADDR_WIDTH-1:0] cfg_src,
    input  logic [ADDR_WIDTH-1:0] cfg_dst,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic                  intr_clr,
    output logic                  busy,
    output logic                  done,
    output logic                  intr,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  wr_en,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic                  ready,
    input  logic [DATA_WIDTH-1:0] rdata,
`ifdef DMA_ABORT_EN
    input  logic                  abort,
`endif
    output dma_xfer_state_t       dbg_state
);

    // Bus handshake: a request is accepted on the clock edge where valid & ready;
    // while valid is high and ready low, addr/wr_en/wdata are held unchanged.

    dma_xfer_state_t       r_state;
    logic [LEN_WIDTH-1:0]  r_remaining;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_intr;
    logic                  r_valid;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_addr;

    logic                  w_start;
    logic                  w_abort;
    logic                  w_src_inc;
    logic                  w_dst_inc;
    logic [ADDR_WIDTH-1:0] w_src;
    logic [ADDR_WIDTH-1:0] w_dst;

    assign w_start = (r_state == IDLE) && cfg_start;

`ifdef DMA_ABORT_EN
    assign w_abort = abort && ((r_state == RD_REQ) || (r_state == RD_WAIT) || (r_state == WR_REQ));
`else
    assign w_abort = 1'b0;
`endif

    assign w_src_inc = (r_state == RD_WAIT) && !w_abort;
    assign w_dst_inc = (r_state == WR_REQ) && ready && !w_abort;

    dma_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_src_gen (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_start),
        .i_load_addr (cfg_src),
        .i_inc       (w_src_inc),
        .o_addr      (w_src)
    );

    dma_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_dst_gen (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_start),
        .i_load_addr (cfg_dst),
        .i_inc       (w_dst_inc),
        .o_addr      (w_dst)
    );

    // Outputs are registered for the state being entered; a later set of r_intr
    // in the same cycle overrides the intr_clr default, so set wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_data      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_intr      <= 1'b0;
            r_valid     <= 1'b0;
            r_wr_en     <= 1'b0;
            r_addr      <= '0;
        end else begin
            r_done <= 1'b0;
            if (intr_clr) begin
                r_intr <= 1'b0;
            end
            if (w_abort) begin
                r_state <= DONE;
                r_valid <= 1'b0;
                r_wr_en <= 1'b0;
                r_done  <= 1'b1;
                r_intr  <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (cfg_start) begin
                            r_busy      <= 1'b1;
                            r_remaining <= cfg_len;
                            if (cfg_len == '0) begin
                                r_state <= DONE;
                                r_done  <= 1'b1;
                                r_intr  <= 1'b1;
                            end else begin
                                r_state <= RD_REQ;
                                r_valid <= 1'b1;
                                r_wr_en <= 1'b0;
                                r_addr  <= cfg_src;
                            end
                        end
                    end
                    RD_REQ: begin
                        if (ready) begin
                            r_state <= RD_WAIT;
                            r_valid <= 1'b0;
                        end
                    end
                    RD_WAIT: begin
                        r_data  <= rdata;
                        r_state <= WR_REQ;
                        r_valid <= 1'b1;
                        r_wr_en <= 1'b1;
                        r_addr  <= w_dst;
                    end
                    WR_REQ: begin
                        if (ready) begin
                            r_remaining <= r_remaining - LEN_WIDTH'(1);
                            r_wr_en     <= 1'b0;
                            if (r_remaining == LEN_WIDTH'(1)) begin
                                r_state <= DONE;
                                r_valid <= 1'b0;
                                r_done  <= 1'b1;
                                r_intr  <= 1'b1;
                            end else begin
                                r_state <= RD_REQ;
                                r_addr  <= w_src;
                            end
                        end
                    end
                    DONE: begin
                        r_intr  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign intr      = r_intr;
    assign addr      = r_addr;
    assign wr_en     = r_wr_en;
    assign valid     = r_valid;
    assign wdata     = r_data;
    assign dbg_state = r_state;

endmodule

// File: doc/dma_xfer_ctrl.md
# dma_xfer_ctrl

Transfer sequencer for the DMA register block. It latches a source address, destination address and word count, then moves the words one at a time over the shared register/memory bus (addr, wr_en, valid, wdata, rdata): one read, then one write, per word. When the transfer finishes it raises a sticky interrupt. It sits between the software-programmed DMA registers and the bus, acting as the only bus master while busy.

## Interface
- ADDR_WIDTH, 32, bus address width
- DATA_WIDTH, 32, bus data width; address stride per word is DATA_WIDTH/8
- LEN_WIDTH, 16, word-count width
- clk  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- cfg_start  in  1  one-cycle start pulse
- cfg_src  in  ADDR_WIDTH  source byte address
- cfg_dst  in  ADDR_WIDTH  destination byte address
- cfg_len  in  LEN_WIDTH  number of words to move
- intr_clr  in  1  clears intr
- busy  out  1  high from the cycle after an accepted start until the done cycle, inclusive
- done  out  1  one-cycle pulse at transfer end
- intr  out  1  sticky; set with done
- addr  out  ADDR_WIDTH  bus address
- wr_en  out  1  1 = write, 0 = read
- valid  out  1  bus request
- wdata  out  DATA_WIDTH  write data
- ready  in  1  bus accepts the request when valid & ready
- rdata  in  DATA_WIDTH  read data; valid exactly one cycle after the read handshake
- abort  in  1  present only with DMA_ABORT_EN (see Configuration)

## Operation
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
- IDLE: on cfg_start, latch src/dst/len into internal registers.
  - len != 0 → RD_REQ.
  - len == 0 → DONE, with no bus traffic.
  - cfg_start in any state other than IDLE is ignored; the latched configuration does not change.
- RD_REQ: drive valid=1, wr_en=0, addr=src.
  - Hold all three stable until ready.
  - On handshake → RD_WAIT.
- RD_WAIT: capture rdata into the data register; src += DATA_WIDTH/8 → WR_REQ.
- WR_REQ: drive valid=1, wr_en=1, addr=dst, wdata=data register.
  - Hold until ready.
  - On handshake: dst += DATA_WIDTH/8, remaining -= 1.
  - Next state is DONE if remaining was 1, otherwise RD_REQ.
- DONE: done=1 for one cycle; intr set → IDLE.
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap-around is silent.
- remaining is LEN_WIDTH bits; a maximum cfg_len of 2^LEN_WIDTH-1 is legal.
- intr priority:
  - intr_clr in the same cycle as DONE: set wins.
  - Otherwise intr_clr clears intr.
- Reset values: state=IDLE, busy=0, done=0, intr=0, valid=0, wr_en=0, addr=0, wdata=0, internal registers=0.
- Reset mid-transfer returns to IDLE next cycle; the request is dropped even if it was not yet accepted.

## Timing
- Start accepted at cycle T; first valid at T+1.
- Each word costs 3 cycles when ready is held high: RD_REQ, RD_WAIT, WR_REQ.
- Each stall cycle (valid & !ready) adds 1 cycle.
- With ready held high, done is at T+3N+1 (N = cfg_len); for len=0, done is at T+1.
- valid is never asserted in RD_WAIT, DONE or IDLE.
- All outputs are registered.

## Configuration
- DMA_ABORT_EN defined:
  - abort port exists.
  - abort=1 in RD_REQ, RD_WAIT or WR_REQ forces DONE next cycle.
  - A write in progress is not completed; valid drops.
  - done and intr are raised as normal; remaining is left at its residual value.
  - abort is ignored in IDLE and DONE.
- DMA_ABORT_EN undefined: no abort port; transfers always run to completion.

## Structure
- Package dma_pkg holds:
  - the FSM state enum dma_xfer_state_t (IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE);
  - register offset constants DMA_INTR_OFS=32'h400, DMA_CTRL_OFS=32'h404, DMA_IO_ADDR_OFS=32'h408, DMA_MEM_ADDR_OFS=32'h40C.
- One sub-module, dma_addr_gen: loadable address register with a +DATA_WIDTH/8 increment enable. Instantiated twice, for src and dst.

## Test plan
- Basic: src=0x1000, dst=0x2000, len=2, ready tied 1, memory returns 0xA5A5_0001 then 0xA5A5_0002.
  - Reads at 0x1000 and 0x1004; writes of those values to 0x2000 and 0x2004.
  - done at T+7; intr=1.
- Backpressure: len=1, ready low for 3 cycles on each request.
  - addr, wr_en and wdata stay stable throughout the stall.
  - done at T+10.
- Zero length: len=0.
  - No valid asserted; done and intr at T+1.
- Wrap and ignore: src=0xFFFF_FFFC, len=2.
  - Second read address is 0x0000_0000.
  - A cfg_start pulsed mid-transfer is ignored, with no change to the address sequence.
- Reset and intr: reset asserted in WR_REQ → next cycle valid=0, busy=0, intr=0.
  - Separately, intr_clr in the DONE cycle leaves intr=1; intr_clr one cycle later clears it.
- Abort (DMA_ABORT_EN only): len=4, abort asserted during the second RD_REQ.
  - done follows one cycle later; exactly one write was issued.
